// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between the instruction (read-only) and data (read/write)
// channels: one outstanding transaction, data priority with a bounded data streak.
module sram_req_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                proto_err
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int STREAK_W = $clog2(DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_STREAK);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                owner_q, owner_d;   // 1: data channel owns the transaction
    logic                wr_q, wr_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                proto_err_q, proto_err_d;
    logic                grant_inst, grant_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            streak_q    <= '0;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            wstrb_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            wstrb_q     <= wstrb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        wstrb_d     = wstrb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        grant_inst  = 1'b0;
        grant_data  = 1'b0;
        proto_err_d = proto_err_q | (mem_data_ok && (state_q != S_WAIT));

        case (state_q)
            S_IDLE: begin
                // inst only overrides data once data has won DATA_STREAK times in a row
                if (data_req && !(inst_req && (streak_q == STREAK_MAX))) begin
                    grant_data = 1'b1;
                end else if (inst_req) begin
                    grant_inst = 1'b1;
                end

                if (grant_data) begin
                    state_d = S_REQ;
                    owner_d = 1'b1;
                    wr_d    = data_wr;
                    wstrb_d = data_wr ? data_wstrb : '0;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    if (inst_req) begin
                        if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_inst) begin
                    state_d  = S_REQ;
                    owner_d  = 1'b0;
                    wr_d     = 1'b0;
                    wstrb_d  = '0;
                    addr_d   = inst_addr;
                    wdata_d  = '0;
                    streak_d = '0;
                end
            end
            S_REQ: begin
                if (mem_addr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = (state_q == S_WAIT) && mem_data_ok && !owner_q;
    assign data_data_ok = (state_q == S_WAIT) && mem_data_ok && owner_q;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign mem_req   = (state_q == S_REQ);
    assign mem_wr    = wr_q;
    assign mem_wstrb = wstrb_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: reference arbitration model with command/response
// queues, a table of single transactions, and hand sequences for streak, reset and protocol corners.
module tb_sram_req_arbiter;

    localparam int DS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        proto_err;

    sram_req_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_STREAK(DS)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .proto_err(proto_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic is_data;
        logic wr;
    } resp_t;

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        exp_wr;
        logic [3:0]  exp_wstrb;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    cmd_t  cmd_q[$];
    resp_t resp_q[$];
    bit    grant_log[$];
    bit    m_busy = 0;
    int    m_streak = 0;

    logic        resp_en = 1'b1;
    bit          resp_pend = 0;
    int          wait_cnt = 0;
    int          mem_lat = 0;
    logic [31:0] rd_val = '0;

    logic        last_mem_wr;
    logic [3:0]  last_mem_wstrb;
    logic [31:0] last_mem_wdata, last_rdata;
    int          last_grant_cyc = 0, last_dok_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory responder: mem_addr_ok after mem_lat waiting cycles, mem_data_ok the cycle after
    initial forever begin
        @(posedge clk);
        #1;
        if (resp_en) begin
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            if (resp_pend) begin
                mem_data_ok = 1'b1;
                mem_rdata   = rd_val;
                resp_pend   = 0;
            end else if (mem_req) begin
                if (wait_cnt >= mem_lat) begin
                    mem_addr_ok = 1'b1;
                    wait_cnt    = 0;
                    resp_pend   = 1;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // reference model and scoreboard, sampled mid-cycle
    initial forever begin
        bit    exp_d, exp_i;
        cmd_t  c;
        resp_t r;
        @(negedge clk);
        if (reset) begin
            m_busy   = 0;
            m_streak = 0;
            cmd_q.delete();
            resp_q.delete();
        end else begin
            exp_d = !m_busy && data_req && !(inst_req && (m_streak == DS));
            exp_i = !m_busy && inst_req && !exp_d;
            chk("data_addr_ok", 32'(data_addr_ok), 32'(exp_d));
            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_i));
            if (exp_d) begin
                c.wr = data_wr; c.wstrb = data_wr ? data_wstrb : 4'h0;
                c.addr = data_addr; c.wdata = data_wdata;
                cmd_q.push_back(c);
                r.is_data = 1'b1; r.wr = data_wr;
                resp_q.push_back(r);
                m_streak = inst_req ? ((m_streak == DS) ? DS : m_streak + 1) : 0;
                m_busy = 1;
                grant_log.push_back(1'b1);
                last_grant_cyc = cyc;
            end else if (exp_i) begin
                c.wr = 1'b0; c.wstrb = 4'h0; c.addr = inst_addr; c.wdata = '0;
                cmd_q.push_back(c);
                r.is_data = 1'b0; r.wr = 1'b0;
                resp_q.push_back(r);
                m_streak = 0;
                m_busy = 1;
                grant_log.push_back(1'b0);
                last_grant_cyc = cyc;
            end

            if (mem_req) begin
                if (cmd_q.size() == 0) begin
                    chk("mem_req without grant", 32'(mem_req), 32'h0);
                end else begin
                    c = cmd_q[0];
                    chk("mem_wr", 32'(mem_wr), 32'(c.wr));
                    chk("mem_wstrb", 32'(mem_wstrb), 32'(c.wstrb));
                    chk("mem_addr", mem_addr, c.addr);
                    if (c.wr) chk("mem_wdata", mem_wdata, c.wdata);
                    if (mem_addr_ok) begin
                        last_mem_wr    = mem_wr;
                        last_mem_wstrb = mem_wstrb;
                        last_mem_wdata = mem_wdata;
                        void'(cmd_q.pop_front());
                    end
                end
            end

            if (inst_data_ok && data_data_ok) chk("dual data_ok", 32'h1, 32'h0);
            if (inst_data_ok || data_data_ok) begin
                if (resp_q.size() == 0) begin
                    chk("spurious data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
                end else begin
                    r = resp_q.pop_front();
                    chk("data_ok channel", 32'(data_data_ok), 32'(r.is_data));
                    last_rdata = r.is_data ? data_rdata : inst_rdata;
                    if (!r.wr) chk("rdata", last_rdata, rd_val);
                    last_dok_cyc = cyc;
                    m_busy = 0;
                end
            end
        end
    end

    task automatic drive_inst(input logic [31:0] a);
        int n = 0;
        inst_req  = 1'b1;
        inst_addr = a;
        forever begin
            @(negedge clk);
            if (inst_addr_ok) break;
            if (++n > 60) begin
                chk("inst accept timeout", 32'(n), 32'h0);
                break;
            end
        end
        @(posedge clk);
        #1;
        inst_req = 1'b0;
    endtask

    task automatic drive_data(input logic w, input logic [3:0] s, input logic [31:0] a,
                              input logic [31:0] d);
        int n = 0;
        data_req   = 1'b1;
        data_wr    = w;
        data_wstrb = s;
        data_addr  = a;
        data_wdata = d;
        forever begin
            @(negedge clk);
            if (data_addr_ok) break;
            if (++n > 60) begin
                chk("data accept timeout", 32'(n), 32'h0);
                break;
            end
        end
        @(posedge clk);
        #1;
        data_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!m_busy && resp_q.size() == 0 && cmd_q.size() == 0) break;
            if (++n > 100) begin
                chk("idle timeout", 32'(n), 32'h0);
                break;
            end
        end
    endtask

    initial begin
        vec_t vecs[5];
        bit   exp_seq[7];

        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'hBFC00000, 32'h0,        32'h24010001, 0, 1'b0, 4'h0};
        vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h00001000, 32'hDEADBEEF, 32'h11111111, 0, 1'b1, 4'hF};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h00002004, 32'h55555555, 32'hCAFEF00D, 2, 1'b0, 4'h0};
        vecs[3] = '{1'b1, 1'b1, 4'h5, 32'h00003008, 32'h01234567, 32'h22222222, 5, 1'b1, 4'h5};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'hBFC00004, 32'h0,        32'h8C220000, 5, 1'b0, 4'h0};
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        @(negedge clk);
        chk("rst inst_addr_ok", 32'(inst_addr_ok), 32'h0);
        chk("rst data_addr_ok", 32'(data_addr_ok), 32'h0);
        chk("rst mem_req", 32'(mem_req), 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst proto_err", 32'(proto_err), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            mem_lat = vecs[i].lat;
            rd_val  = vecs[i].rdata;
            @(posedge clk);
            #1;
            if (vecs[i].is_data) drive_data(vecs[i].wr, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata);
            else drive_inst(vecs[i].addr);
            wait_idle();
            chk($sformatf("vec%0d mem_wr", i), 32'(last_mem_wr), 32'(vecs[i].exp_wr));
            chk($sformatf("vec%0d mem_wstrb", i), 32'(last_mem_wstrb), 32'(vecs[i].exp_wstrb));
            if (vecs[i].exp_wr) chk($sformatf("vec%0d mem_wdata", i), last_mem_wdata, vecs[i].wdata);
            else chk($sformatf("vec%0d rdata", i), last_rdata, vecs[i].rdata);
            chk($sformatf("vec%0d latency", i), 32'(last_dok_cyc - last_grant_cyc),
                32'(vecs[i].lat + 2));
        end

        // simultaneous requests: data first, inst in the next IDLE
        mem_lat = 0;
        rd_val  = 32'h0BADF00D;
        grant_log.delete();
        @(posedge clk);
        #1;
        fork
            drive_data(1'b1, 4'hF, 32'h00001000, 32'hDEADBEEF);
            drive_inst(32'hBFC00000);
        join
        wait_idle();
        chk("both grant count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            chk("both first is data", 32'(grant_log[0]), 32'h1);
            chk("both second is inst", 32'(grant_log[1]), 32'h0);
        end

        // continuous data with inst held: streak limit then inst, then data resumes
        grant_log.delete();
        @(posedge clk);
        #1;
        fork
            drive_inst(32'hBFC00100);
            begin
                for (int k = 0; k < 6; k++) drive_data(1'b0, 4'h3, 32'h4000 + 32'(k * 4), 32'h0);
            end
        join
        wait_idle();
        chk("streak grant count", 32'(grant_log.size()), 32'd7);
        for (int k = 0; k < 7; k++) begin
            if (k < grant_log.size())
                chk($sformatf("streak grant%0d", k), 32'(grant_log[k]), 32'(exp_seq[k]));
        end

        // reset while waiting for the memory response
        resp_en  = 1'b0;
        @(posedge clk);
        #1;
        drive_data(1'b1, 4'hA, 32'h00002000, 32'h12345678);
        mem_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        mem_addr_ok = 1'b0;
        reset       = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0;
        @(negedge clk);
        chk("rstwait data_data_ok", 32'(data_data_ok), 32'h0);
        chk("rstwait inst_data_ok", 32'(inst_data_ok), 32'h0);
        chk("rstwait proto_err", 32'(proto_err), 32'h0);
        @(posedge clk);
        #1;
        mem_data_ok = 1'b0;
        reset       = 1'b0;
        @(negedge clk);
        chk("postrst mem_req", 32'(mem_req), 32'h0);
        chk("postrst mem_wr", 32'(mem_wr), 32'h0);
        chk("postrst mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("postrst mem_addr", mem_addr, 32'h0);
        chk("postrst mem_wdata", mem_wdata, 32'h0);
        chk("postrst data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
        resp_pend = 0;
        wait_cnt  = 0;
        resp_en   = 1'b1;
        rd_val    = 32'h0000ABCD;
        @(posedge clk);
        #1;
        drive_inst(32'hBFC00008);
        wait_idle();
        chk("postrst inst rdata", last_rdata, 32'h0000ABCD);

        // mem_data_ok while IDLE sets the sticky protocol error
        resp_en = 1'b0;
        @(posedge clk);
        #1;
        mem_data_ok = 1'b1;
        @(negedge clk);
        chk("proto data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
        @(posedge clk);
        #1;
        mem_data_ok = 1'b0;
        @(negedge clk);
        chk("proto_err set", 32'(proto_err), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        resp_en = 1'b1;
        drive_data(1'b0, 4'h0, 32'h00005000, 32'h0);
        wait_idle();
        chk("proto_err sticky", 32'(proto_err), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
